// File: rtl/receiver_buffer_if.sv
// ---------------------------------------------------------------------------
// receiver_buffer_if
// Bundles the byte input, the block handshake and the status outputs of the
// receive-side block assembler.
//   master : UART receiver / AES side (drives rx_data, rx_done, block_ack)
//   slave  : receiver_buffer (drives block_out, block_valid, byte_count,
//            overflow, timeout)
// ---------------------------------------------------------------------------
interface receiver_buffer_if;
  logic [7:0]   rx_data;
  logic         rx_done;
  logic         block_ack;
  logic [127:0] block_out;
  logic         block_valid;
  logic [4:0]   byte_count;
  logic         overflow;
  logic         timeout;

  modport master (
    output rx_data, rx_done, block_ack,
    input  block_out, block_valid, byte_count, overflow, timeout
  );

  modport slave (
    input  rx_data, rx_done, block_ack,
    output block_out, block_valid, byte_count, overflow, timeout
  );
endinterface

// File: rtl/receiver_buffer.sv
// ---------------------------------------------------------------------------
// receiver_buffer
// Packs 16 received UART bytes into a 128-bit block (first byte in [127:120],
// last in [7:0]) and offers it to the AES core with a valid/ack handshake.
// A partial block that sees no byte for TIMEOUT_CYCLES cycles is discarded.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - receiver_buffer_if.slave (rx_data/rx_done in, block_ack in,
//           block_out/block_valid/byte_count/overflow/timeout out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module receiver_buffer #(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              reset,
  receiver_buffer_if.slave  bus
);

  localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
  // Timer value seen on the cycle in which it would reach TIMEOUT_CYCLES.
  localparam logic [TMR_W-1:0] TMR_LAST = TMO_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       block_q, block_d;
  logic [4:0]         count_q, count_d;
  logic               valid_q, valid_d;
  logic               ovf_q,   ovf_d;
  logic               tmo_q,   tmo_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      block_q <= 128'd0;
      count_q <= 5'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      timer_q <= timer_d;
    end
  end

  // Next-state, byte packing, idle timer and status flag logic.
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    tmo_d   = 1'b0;
    timer_d = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_done) begin
          block_d = {block_q[119:0], bus.rx_data};
          count_d = 5'd1;
          timer_d = '0;
          state_d = ST_COLLECT;
        end else begin
          timer_d = '0;
        end
      end

      ST_COLLECT: begin
        if (bus.rx_done) begin
          // A byte in the expiry cycle wins over the timeout.
          block_d = {block_q[119:0], bus.rx_data};
          count_d = count_q + 5'd1;
          timer_d = '0;
          if (count_q == 5'd15) begin
            state_d = ST_FULL;
            valid_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (TMO_EN && (timer_q == TMR_LAST)) begin
          count_d = 5'd0;
          timer_d = '0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (TMO_EN) begin
          timer_d = timer_q + TMR_W'(1);
        end else begin
          timer_d = '0;
        end
      end

      ST_FULL: begin
        timer_d = '0;
        if (bus.block_ack) begin
          valid_d = 1'b0;
          if (bus.rx_done) begin
            // Ack frees the buffer in the same cycle, so the byte starts
            // the next block instead of overflowing.
            block_d = {block_q[119:0], bus.rx_data};
            count_d = 5'd1;
            state_d = ST_COLLECT;
          end else begin
            count_d = 5'd0;
            state_d = ST_IDLE;
          end
        end else if (bus.rx_done) begin
          ovf_d = 1'b1;
        end else begin
          state_d = ST_FULL;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = 5'd0;
        valid_d = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  assign bus.block_out   = block_q;
  assign bus.block_valid = valid_q;
  assign bus.byte_count  = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.timeout     = tmo_q;

endmodule

// File: tb/tb_receiver_buffer.sv
// ---------------------------------------------------------------------------
// tb_receiver_buffer
// Table-driven bench: each record holds the inputs for one clock cycle and
// the outputs expected right after that edge. Records are queued as expected
// results when driven and popped for comparison once the edge has happened.
// ---------------------------------------------------------------------------
module tb_receiver_buffer;
  localparam int unsigned TMO = 100;
  localparam logic [127:0] BLK_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK_AS = 128'h112233445566778899aabbccddeeffa5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  receiver_buffer_if bus();

  receiver_buffer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic         done;
    logic [7:0]   data;
    logic         ack;
    logic [4:0]   cnt;
    logic         valid;
    logic         ovf;
    logic         tmo;
    logic         chk_blk;
    logic [127:0] blk;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic d, input logic [7:0] b, input logic a,
                              input logic [4:0] c, input logic v, input logic o,
                              input logic t, input logic cb, input logic [127:0] blk);
    vec_t r;
    r.done = d; r.data = b; r.ack = a; r.cnt = c; r.valid = v;
    r.ovf = o; r.tmo = t; r.chk_blk = cb; r.blk = blk;
    return r;
  endfunction

  // One clock cycle: drive at negedge, compare 1 time unit after the posedge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    bus.rx_done   = v.done;
    bus.rx_data   = v.data;
    bus.block_ack = v.ack;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard: got empty queue, want entry");
    end else begin
      e = exp_q.pop_front();
      check("byte_count",  bus.byte_count,  e.cnt);
      check("block_valid", bus.block_valid, e.valid);
      check("overflow",    bus.overflow,    e.ovf);
      check("timeout",     bus.timeout,     e.tmo);
      if (e.chk_blk) check("block_out", bus.block_out, e.blk);
    end
    bus.rx_done   = 1'b0;
    bus.block_ack = 1'b0;
  endtask

  // Assert reset between clock edges and check outputs clear with no clock.
  task automatic do_reset(input string tag);
    bus.rx_done   = 1'b0;
    bus.block_ack = 1'b0;
    bus.rx_data   = 8'h00;
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_block_out"},   bus.block_out,   128'd0);
    check({tag, "_block_valid"}, bus.block_valid, 1'b0);
    check({tag, "_byte_count"},  bus.byte_count,  5'd0);
    check({tag, "_overflow"},    bus.overflow,    1'b0);
    check({tag, "_timeout"},     bus.timeout,     1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sixteen back-to-back bytes taken MSB-first from blk, final block checked.
  task automatic send_block(input logic [127:0] blk);
    for (int i = 0; i < 16; i++)
      apply(mk(1'b1, blk[127-8*i -: 8], 1'b0, 5'(i + 1), (i == 15), 1'b0, 1'b0,
               (i == 15), blk));
  endtask

  initial begin
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.block_ack = 1'b0;
    reset         = 1'b0;
    #1;
    do_reset("rst_init");

    // Full block with gaps, ack, ack ignored while empty, refill, overflow.
    for (int i = 0; i < 16; i++) begin
      tbl.push_back(mk(1'b1, 8'(i * 17), 1'b0, 5'(i + 1), (i == 15), 1'b0, 1'b0,
                       (i == 15), BLK_A));
      if (i < 15) tbl.push_back(mk(1'b0, 8'h00, 1'b0, 5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, '0));
    end
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BLK_A));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BLK_A));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1'b1, 8'(i), 1'b0, 5'(i + 1), (i == 15), 1'b0, 1'b0, (i == 15), BLK_B));
    tbl.push_back(mk(1'b1, 8'h5a, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, BLK_B));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, BLK_B));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, BLK_B));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Simultaneous ack and byte in FULL.
    do_reset("rst_sim");
    send_block(BLK_A);
    apply(mk(1'b1, 8'ha5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, BLK_AS));

    // Timeout after exactly TMO idle cycles, then a clean block.
    do_reset("rst_tmo");
    for (int i = 0; i < 5; i++)
      apply(mk(1'b1, 8'(i), 1'b0, 5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, '0));
    for (int k = 1; k < TMO; k++)
      apply(mk(1'b0, 8'h00, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    apply(mk(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    apply(mk(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    send_block(BLK_A);
    apply(mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BLK_A));

    // A byte in the expiry cycle prevents the timeout.
    for (int i = 0; i < 5; i++)
      apply(mk(1'b1, 8'(i), 1'b0, 5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, '0));
    for (int k = 1; k < TMO; k++)
      apply(mk(1'b0, 8'h00, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    apply(mk(1'b1, 8'h77, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    apply(mk(1'b0, 8'h00, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, '0));

    // Reset mid-block, then a full block assembles from scratch.
    do_reset("rst_pre");
    for (int i = 0; i < 8; i++)
      apply(mk(1'b1, 8'(8'hc0 + i), 1'b0, 5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, '0));
    do_reset("rst_mid");
    send_block(BLK_A);
    apply(mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BLK_A));

    // Loopback byte order: transmitter sends [127:120] first.
    send_block(BLK_A);
    check("loopback_block",    bus.block_out, BLK_A);
    check("loopback_overflow", bus.overflow,  1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/receiver_buffer.md
# receiver_buffer

Receive-side block assembler for the AES serial link. It consumes bytes from the UART receiver (`rx_data`/`rx_done`) and packs 16 of them into a 128-bit block. It presents the block to the AES core with a valid/ack handshake. It is the receive-path counterpart of `transmitter_buffer`, and its byte order matches so that a loopback returns the same 128-bit value. A partial block that stalls longer than a programmable idle time is discarded.

## Interface
- `TIMEOUT_CYCLES`, default 20000: idle clock cycles allowed between bytes of a partial block before it is discarded; 0 disables the timeout.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  byte from the UART receiver; valid only when `rx_done` is high.
- `rx_done`  in  1  one-cycle pulse marking a received byte.
- `block_ack`  in  1  AES side accepts the block; sampled only while `block_valid` is 1.
- `block_out`  out  128  assembled block; the first received byte is in [127:120] and the last in [7:0].
- `block_valid`  out  1  high while a complete block is held.
- `byte_count`  out  5  bytes held in the current block, 0..16.
- `overflow`  out  1  sticky; set when a byte is dropped because the buffer is full.
- `timeout`  out  1  one-cycle pulse when a partial block is discarded.

## Operation
- **States:**
  - IDLE: `byte_count` = 0.
  - COLLECT: `byte_count` = 1..15.
  - FULL: `byte_count` = 16 and `block_valid` = 1.
- **Byte accept** (IDLE or COLLECT with `rx_done` = 1):
  - `block_out <= {block_out[119:0], rx_data}`.
  - `byte_count` increments.
  - The idle timer clears.
- **State transitions on accept:**
  - IDLE goes to COLLECT.
  - The 16th byte takes COLLECT to FULL.
- **FULL, `block_ack` = 1:**
  - `block_valid` goes to 0 and `byte_count` goes to 0; the state returns to IDLE.
  - `block_out` keeps its value until the next accepted byte shifts it.
- **FULL, `rx_done` = 1 with `block_ack` = 0:**
  - The byte is dropped.
  - `overflow` is set to 1 and stays set until reset.
  - `block_out` and `byte_count` are unchanged.
- **FULL, `rx_done` = 1 and `block_ack` = 1 in the same cycle:**
  - The ack completes.
  - The byte is accepted as the first byte of the next block: state COLLECT, `byte_count` = 1, `block_out[7:0]` = `rx_data`.
  - `overflow` is not set.
- **Idle timer:**
  - Counts only in COLLECT and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES` without an `rx_done`: `byte_count` goes to 0, the state goes to IDLE, and `timeout` pulses for one cycle.
  - If `rx_done` arrives in the expiry cycle, the byte wins; no timeout occurs.
- The timer is inactive in IDLE and FULL; a held full block never times out.
- **Width rules:**
  - `byte_count` is 5 bits and saturates at 16.
  - The idle timer is wide enough to hold `TIMEOUT_CYCLES`, with a minimum of 1 bit.

## Timing
- **Reset values:** `block_out` = 0, `block_valid` = 0, `byte_count` = 0, `overflow` = 0, `timeout` = 0, state IDLE, timer 0.
- Assertion of `reset` at any point, including mid-block or in FULL, returns everything to these values immediately, with no clock needed.
- **Latency:** the `rx_done` sampled at edge N updates `block_out` and `byte_count` at edge N. After the 16th byte, `block_valid` is 1 from edge N onward.
- **Ack:** `block_ack` sampled high at edge M gives `block_valid` = 0 after edge M. `block_ack` is ignored while `block_valid` = 0.
- **Throughput:** back-to-back `rx_done` on consecutive cycles is supported; every pulse is accepted unless the buffer is FULL.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Full block:**
  - Stimulus: 16 `rx_done` pulses with gaps, bytes 0x00,0x11,…,0xff.
  - Required: `block_out` = 128'h00112233445566778899aabbccddeeff, `block_valid` = 1, `byte_count` = 16.
  - Then pulse `block_ack`: `block_valid` = 0 and `byte_count` = 0 on the next cycle.
- **Overflow:**
  - Stimulus: with the block FULL, send byte 0x5a and no ack.
  - Required: `overflow` = 1, `block_out` unchanged, `byte_count` = 16.
  - Then ack: `overflow` is still 1.
- **Simultaneous ack and byte:**
  - Stimulus: in FULL, `block_ack` and `rx_done` high in the same cycle with 0xa5.
  - Required: `block_valid` = 0, `byte_count` = 1, `block_out[7:0]` = 0xa5, `overflow` = 0.
- **Timeout** (`TIMEOUT_CYCLES` = 100):
  - Stimulus: 5 bytes, then 100 idle cycles.
  - Required: a one-cycle `timeout` pulse and `byte_count` = 0.
  - A following 16-byte block assembles correctly.
  - A byte on cycle 100 prevents the timeout.
- **Reset mid-block:**
  - Stimulus: 8 bytes, then assert `reset` between clock edges.
  - Required: all outputs are 0 at once.
  - After release, 16 bytes assemble correctly.
- **Loopback:**
  - Stimulus: `transmitter_buffer` → UART tx → UART rx → `receiver_buffer`, sending 128'h00112233445566778899aabbccddeeff.
  - Required: `block_out` equals the sent block and `overflow` = 0.
